horner_poly_pipe: RTL and testbench
===================================

// Module: horner_poly_pipe
// PURPOSE
//  Parametrised, fully pipelined fixed-point polynomial evaluator (Horner form).
//  y = ((..(C[N]*x + C[N-1])*x ..)*x + C[0]); default coefficients give the 5th-order exp(x) Taylor series.
//  Sits between an upstream sample source and a downstream sink; valid/ready on both sides, true backpressure.
//  Coefficients are run-time programmable through a double-buffered bank with a drain-then-swap commit.
// PARAMETERS
//  WIDTHIN   16  input x and coefficient width (unsigned Q(WIDTHIN-FRAC_IN).FRAC_IN)
//  FRAC_IN   14  fractional bits of x and coefficients
//  WIDTHOUT  32  accumulator/output width (unsigned Q(WIDTHOUT-FRAC_OUT).FRAC_OUT)
//  FRAC_OUT  25  fractional bits of accumulator/output; FRAC_OUT >= FRAC_IN
//  ORDER     5   polynomial order N (>=1); number of multiply-add stages
//  COEF_INIT horner_pkg::EXP_COEF_Q2_14  reset value of both coefficient banks, index 0..ORDER
// PORTS
//  clk          in   1                    clock, all logic rising-edge
//  reset_n      in   1                    asynchronous, active-low reset
//  i_valid      in   1                    upstream sample valid
//  o_ready      out  1                    block accepts sample this cycle
//  i_x          in   WIDTHIN              sample x
//  o_valid      out  1                    o_y holds a result
//  i_ready      in   1                    downstream accepts o_y this cycle
//  o_y          out  WIDTHOUT             result y
//  i_coef_we    in   1                    write shadow coefficient
//  i_coef_addr  in   $clog2(ORDER+1)      shadow index 0..ORDER
//  i_coef_data  in   WIDTHIN              shadow coefficient value
//  i_coef_swap  in   1                    request shadow->active commit (1-cycle pulse)
//  o_swap_busy  out  1                    swap pending (input held off while pipeline drains)
// BEHAVIOUR
//  Reset: o_valid=0, o_y=0, o_swap_busy=0, all stage valids=0, occupancy=0, both banks=COEF_INIT.
//  Pipeline: input reg -> ORDER mul-add stages -> output reg; latency ORDER+2 cycles accept->o_valid, no stall.
//  Global advance: adv = ~o_valid | i_ready. All data/valid regs update only when adv=1.
//  o_ready = adv & ~o_swap_busy. Sample accepted when i_valid & o_ready; result consumed when o_valid & i_ready.
//  Under stall (o_valid & ~i_ready) every stage holds; o_y stable; no sample lost or duplicated.
//  Bubbles are not collapsed: one sample per cycle max, throughput 1/cycle when i_ready=1.
//  Stage 0 acc = C[ORDER] << (FRAC_OUT-FRAC_IN). Stage k: acc = P[WIDTHOUT+FRAC_IN-1:FRAC_IN] + (C[ORDER-k] << (FRAC_OUT-FRAC_IN)),
//   P = acc_prev * x (full WIDTHOUT+WIDTHIN product, unsigned). Add wraps mod 2^WIDTHOUT; no saturation.
//  x travels alongside acc through every stage; each sample uses only its own x.
//  Occupancy counter (0..ORDER+2): +1 on accept, -1 on consume, unchanged on both/neither; never over/underflows.
//  Coef write: i_coef_we writes shadow[i_coef_addr] next edge; addr>ORDER ignored; never affects active bank directly.
//  Swap: i_coef_swap sets o_swap_busy next cycle (unless commit condition already met). While busy, no accepts.
//   Commit when busy & occupancy==0: active<=shadow, o_swap_busy<=0 same edge. Swap with empty pipe commits in 1 cycle.
//   Write and swap in same cycle: commit includes the new write. Swap while busy: no extra effect.
//  Every sample in flight is evaluated entirely with one coefficient set (the active set at its acceptance).
//  Reset mid-operation: all in-flight samples discarded, pending swap dropped, banks return to COEF_INIT.
// STRUCTURE
//  horner_pkg: Q-format constants, coef_t typedef, EXP_COEF_Q2_14 default array
//   (1, 1, 0x2000, 0x0AAA, 0x02AA, 0x0088 for idx 0..5), align function coef->accumulator.
//  Sub-module horner_stage: one registered multiply-truncate-add stage with x pass-through and valid, gated by adv.
//  Top: generate loop of ORDER horner_stage instances, input/output regs, occupancy counter, coef banks/swap FSM
//   (IDLE, DRAIN; DRAIN->IDLE on commit).
// TESTING
//  Reset then x=0x0000, i_ready=1 -> after ORDER+2=7 cycles o_valid=1, o_y=0x0200_0000 (1.0 Q7.25).
//  x=0x4000 (1.0) -> o_y bit-exact vs C model of truncating Horner, ~2.7166 (within 2^-12 of 2.71667).
//  Stream 20 random x, i_ready toggled pseudo-randomly -> all 20 results in order, bit-exact, none dropped/duplicated.
//  Write shadow C[0..5]=0,1,0,0,0,0 then swap with 4 in flight -> o_swap_busy high until 4 drained, those use exp set;
//   next x=0x2000 -> o_y=0x0100_0000 (0.5).
//  Assert reset_n low with pipeline full and swap pending -> o_valid=0, o_swap_busy=0 immediately; restart yields default exp.
//  Write addr 7 (>ORDER) then swap -> active bank unchanged, results identical to default.

Source files
------------

// File: rtl/horner_pkg.sv
// Shared constants, types and default coefficients for the
// pipelined Horner polynomial evaluator.
package horner_pkg;

  localparam int W_IN     = 16;
  localparam int F_IN     = 14;
  localparam int W_OUT    = 32;
  localparam int F_OUT    = 25;
  localparam int ORDER_D  = 5;

  typedef logic [W_IN-1:0] coef_t;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } swap_st_t;

  // exp(x) Taylor terms in Q2.14, packed with index 0 in the LSBs.
  localparam logic [(ORDER_D+1)*W_IN-1:0] EXP_COEF_Q2_14 = {
    16'h0088,
    16'h02AA,
    16'h0AAA,
    16'h2000,
    16'h4000,
    16'h4000
  };

  function automatic logic [W_OUT-1:0] align(coef_t c);
    return W_OUT'(c) << (F_OUT - F_IN);
  endfunction

endpackage

// File: rtl/horner_stage.sv
// One registered Horner step: acc*x truncated, plus aligned coef.
// Ports: adv gate, coef, in/out valid, acc and pass-through x.
module horner_stage
  import horner_pkg::*;
#(
  parameter int WIDTHIN  = 16,
  parameter int FRAC_IN  = 14,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_OUT = 25
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                adv,
  input  logic [WIDTHIN-1:0]  coef,
  input  logic                in_valid,
  input  logic [WIDTHOUT-1:0] in_acc,
  input  logic [WIDTHIN-1:0]  in_x,
  output logic                out_valid,
  output logic [WIDTHOUT-1:0] out_acc,
  output logic [WIDTHIN-1:0]  out_x
);

  localparam int PW = WIDTHOUT + WIDTHIN;
  localparam int SH = FRAC_OUT - FRAC_IN;

  logic [PW-1:0]       prod;
  logic [WIDTHOUT-1:0] sum;

  assign prod = PW'(in_acc) * PW'(in_x);
  // Drop FRAC_IN fraction bits; the add wraps.
  assign sum  = WIDTHOUT'(prod >> FRAC_IN)
              + (WIDTHOUT'(coef) << SH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_x     <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_acc   <= sum;
      out_x     <= in_x;
    end
  end

endmodule

// File: rtl/horner_poly_pipe.sv
// Pipelined fixed-point Horner evaluator with valid/ready and a
// double-buffered coefficient bank committed once the pipe drains.
module horner_poly_pipe
  import horner_pkg::*;
#(
  parameter int WIDTHIN  = 16,
  parameter int FRAC_IN  = 14,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_OUT = 25,
  parameter int ORDER    = 5,
  parameter logic [(ORDER+1)*WIDTHIN-1:0] COEF_INIT =
    EXP_COEF_Q2_14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTHIN-1:0]         i_x,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTHOUT-1:0]        o_y,
  input  logic                       i_coef_we,
  input  logic [$clog2(ORDER+1)-1:0] i_coef_addr,
  input  logic [WIDTHIN-1:0]         i_coef_data,
  input  logic                       i_coef_swap,
  output logic                       o_swap_busy
);

  localparam int OCCW = $clog2(ORDER + 3);
  localparam int SH   = FRAC_OUT - FRAC_IN;

  logic [WIDTHIN-1:0]  act_q [ORDER+1];
  logic [WIDTHIN-1:0]  shd_q [ORDER+1];
  logic [WIDTHIN-1:0]  shd_d [ORDER+1];

  logic                v   [ORDER+1];
  logic [WIDTHOUT-1:0] acc [ORDER+1];
  logic [WIDTHIN-1:0]  xs  [ORDER+1];

  logic                v0_q;
  logic [WIDTHOUT-1:0] acc0_q;
  logic [WIDTHIN-1:0]  x0_q;

  logic            adv, accept, consume, commit;
  logic [OCCW-1:0] occ_q;
  swap_st_t        st_q, st_d;
  logic            unused_x;

  assign adv         = ~o_valid | i_ready;
  assign o_swap_busy = (st_q == S_DRAIN);
  assign o_ready     = adv & ~o_swap_busy;
  assign accept      = i_valid & o_ready;
  assign consume     = o_valid & i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      unique case ({accept, consume})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_comb begin
    shd_d = shd_q;
    if (i_coef_we && (int'(i_coef_addr) <= ORDER))
      shd_d[i_coef_addr] = i_coef_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= ORDER; i++) begin
        act_q[i] <= COEF_INIT[i*WIDTHIN +: WIDTHIN];
        shd_q[i] <= COEF_INIT[i*WIDTHIN +: WIDTHIN];
      end
    end else begin
      shd_q <= shd_d;
      if (commit)
        act_q <= shd_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= S_IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (i_coef_swap && !commit) st_d = S_DRAIN;
      S_DRAIN: if (commit)                 st_d = S_IDLE;
    endcase
  end

  // A sample accepted this cycle already uses the old set,
  // so an immediate commit needs an empty pipe and no accept.
  always_comb begin
    commit = 1'b0;
    unique case (st_q)
      S_IDLE:  commit = i_coef_swap & (occ_q == '0) & ~accept;
      S_DRAIN: commit = (occ_q == '0);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q   <= 1'b0;
      acc0_q <= '0;
      x0_q   <= '0;
    end else if (adv) begin
      v0_q   <= accept;
      acc0_q <= WIDTHOUT'(act_q[ORDER]) << SH;
      x0_q   <= i_x;
    end
  end

  assign v[0]   = v0_q;
  assign acc[0] = acc0_q;
  assign xs[0]  = x0_q;

  for (genvar k = 1; k <= ORDER; k++) begin : g_stage
    horner_stage #(
      .WIDTHIN  (WIDTHIN),
      .FRAC_IN  (FRAC_IN),
      .WIDTHOUT (WIDTHOUT),
      .FRAC_OUT (FRAC_OUT)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .adv       (adv),
      .coef      (act_q[ORDER-k]),
      .in_valid  (v[k-1]),
      .in_acc    (acc[k-1]),
      .in_x      (xs[k-1]),
      .out_valid (v[k]),
      .out_acc   (acc[k]),
      .out_x     (xs[k])
    );
  end

  assign unused_x = ^xs[ORDER];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_y     <= '0;
    end else if (adv) begin
      o_valid <= v[ORDER];
      o_y     <= acc[ORDER];
    end
  end

endmodule

// File: tb/tb_horner_poly_pipe.sv
// Self-checking bench for horner_poly_pipe: vector table,
// random backpressure stream, coefficient swap and reset cases.
module tb_horner_poly_pipe;

  localparam int ORDER = 5;
  localparam logic [15:0] DEF [6] = '{
    16'h4000, 16'h4000, 16'h2000,
    16'h0AAA, 16'h02AA, 16'h0088
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_x;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_y;
  logic        i_coef_we;
  logic [2:0]  i_coef_addr;
  logic [15:0] i_coef_data;
  logic        i_coef_swap;
  logic        o_swap_busy;

  always #5 clk = ~clk;

  horner_poly_pipe dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_x         (i_x),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_y         (o_y),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .i_coef_swap (i_coef_swap),
    .o_swap_busy (o_swap_busy)
  );

  typedef struct {
    logic [15:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t        tv [8];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = -1;
  int          first_v = -1;
  int          n_out = 0;
  bit          pending = 0;
  bit          stall_prev = 0;
  bit          use_ovr = 0;
  bit          last_acc = 0;
  logic [31:0] ovr_y;
  logic [31:0] y_prev;
  logic [31:0] q [$];
  logic [15:0] m_act [6];
  logic [15:0] m_shd [6];

  function automatic logic [31:0] model(logic [15:0] x);
    logic [47:0] p;
    logic [31:0] a;
    a = {16'b0, m_act[5]} << 11;
    for (int k = 1; k <= ORDER; k++) begin
      p = {16'b0, a} * {32'b0, x};
      a = p[45:14] + ({16'b0, m_act[5-k]} << 11);
    end
    return a;
  endfunction

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge with inputs set; returns at
  // the next negedge.
  task automatic cycle();
    bit acc;
    bit con;
    int occ;
    cyc++;
    #1;
    check("swap_busy", 64'(o_swap_busy), 64'(pending));
    if (stall_prev) begin
      check("stall_valid", 64'(o_valid), 64'd1);
      check("stall_y", 64'(o_y), 64'(y_prev));
    end
    if (o_valid && first_v < 0) first_v = cyc;
    acc = i_valid && o_ready;
    con = o_valid && i_ready;
    occ = q.size();
    if (con) begin
      n_out++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_out: got %0h expected none", o_y);
      end else begin
        check("y", 64'(o_y), 64'(q.pop_front()));
      end
    end
    if (acc) begin
      q.push_back(use_ovr ? ovr_y : model(i_x));
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (i_coef_we && i_coef_addr <= 3'(ORDER))
      m_shd[i_coef_addr] = i_coef_data;
    if ((pending || i_coef_swap) && occ == 0 && !acc) begin
      m_act = m_shd;
      pending = 0;
    end else if (i_coef_swap) begin
      pending = 1;
    end
    last_acc = acc;
    stall_prev = o_valid && !i_ready;
    y_prev = o_y;
    @(negedge clk);
  endtask

  task automatic send(logic [15:0] x, bit ovr,
                      logic [31:0] y);
    bit got;
    got = 0;
    i_valid = 1'b1;
    i_x = x;
    use_ovr = ovr;
    ovr_y = y;
    for (int n = 0; n < 100 && !got; n++) begin
      cycle();
      got = last_acc;
    end
    i_valid = 1'b0;
    use_ovr = 0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got none expected accept");
    end
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 60 && q.size() != 0; n++)
      cycle();
    check("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_swap_busy), 64'd0);
    q.delete();
    pending = 0;
    stall_prev = 0;
    m_act = DEF;
    m_shd = DEF;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic write_shadow(logic [2:0] a, logic [15:0] d);
    i_coef_we = 1'b1;
    i_coef_addr = a;
    i_coef_data = d;
    cycle();
    i_coef_we = 1'b0;
  endtask

  task automatic pulse_swap();
    i_coef_swap = 1'b1;
    cycle();
    i_coef_swap = 1'b0;
  endtask

  initial begin
    int c0;
    int sent;
    int o0;
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_x = '0;
    i_ready = 1'b1;
    i_coef_we = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    i_coef_swap = 1'b0;
    m_act = DEF;
    m_shd = DEF;
    @(negedge clk);
    #1;
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_y", 64'(o_y), 64'd0);
    check("reset_busy", 64'(o_swap_busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_o_ready", 64'(o_ready), 64'd1);

    // Latency of a single sample, x = 0 gives 1.0.
    send(16'h0000, 1, 32'h0200_0000);
    drain();
    check("latency", 64'(first_v - acc_cyc), 64'd7);

    // Vector table streamed back to back.
    tv[0] = '{16'h0000, 32'h0200_0000};
    tv[1] = '{16'h4000, 32'h056E_E000};
    tv[2] = '{16'h2000, model(16'h2000)};
    tv[3] = '{16'h1000, model(16'h1000)};
    tv[4] = '{16'h7FFF, model(16'h7FFF)};
    tv[5] = '{16'hFFFF, model(16'hFFFF)};
    tv[6] = '{16'h0001, model(16'h0001)};
    tv[7] = '{16'h8000, model(16'h8000)};
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(tv[i].x, 1, tv[i].y);
    check("throughput", 64'(cyc - c0), 64'd8);
    drain();

    // Random stream with random backpressure.
    sent = 0;
    o0 = n_out;
    for (int n = 0; n < 500 && sent < 20; n++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_x = 16'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) sent++;
    end
    i_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd20);
    drain();
    check("rand_out", 64'(n_out - o0), 64'd20);

    // Swap to y = x with four samples in flight.
    for (int i = 0; i <= ORDER; i++)
      write_shadow(3'(i), (i == 1) ? 16'h4000 : 16'h0000);
    for (int i = 0; i < 4; i++)
      send(16'($urandom), 0, '0);
    pulse_swap();
    #1;
    check("busy_after_swap", 64'(o_swap_busy), 64'd1);
    send(16'h2000, 1, 32'h0100_0000);
    drain();

    // Reset with full stalled pipe and swap pending.
    for (int i = 0; i <= ORDER; i++)
      write_shadow(3'(i), 16'h1234);
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(16'($urandom), 0, '0);
    pulse_swap();
    do_reset();
    i_ready = 1'b1;
    send(16'h4000, 1, 32'h056E_E000);
    send(16'h0000, 1, 32'h0200_0000);
    drain();

    // Out-of-range shadow write then swap.
    write_shadow(3'd7, 16'hFFFF);
    pulse_swap();
    send(16'h4000, 1, 32'h056E_E000);
    send(16'h0000, 1, 32'h0200_0000);
    send(16'h2000, 0, '0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
